lcd_sync_timing_gen: RTL

//  Consumer end of the 33 MHz pixel-clock PLL. It generates 800x480 LCD raster timing
//  (HS, VS, DE) and pixel read requests, then registers returned RGB onto the panel bus.
//  It stays idle until the PLL reports lock and returns to idle whenever lock drops.
//  It sits between the PLL output and the frame/pattern source in the G-sensor display demo.

---
 rtl/lcd_timing_pkg.sv | 35 +++
 rtl/lcd_lock_sync.sv | 36 +++
 rtl/lcd_sync_timing_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_pkg
// Purpose  : Shared timing constants and FSM state type for the 800x480 LCD
//            raster generator fed by the 33 MHz pixel-clock PLL.
// Contents : H_/V_ ACTIVE, FP, SYNC, BP constants, H_TOTAL/V_TOTAL, SYNC_POL,
//            lcd_state_e {IDLE, RUN}.
// Revision : 1.0 - initial release
// ============================================================================
package lcd_timing_pkg;

  // Horizontal timing, in pixel clocks. A line runs ACTIVE, FP, SYNC, BP.
  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 210;
  localparam int H_SYNC   = 20;
  localparam int H_BP     = 26;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1056

  // Vertical timing, in lines. A frame runs ACTIVE, FP, SYNC, BP.
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 22;
  localparam int V_SYNC   = 10;
  localparam int V_BP     = 13;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Active level of HS/VS (0 = active-low).
  localparam bit SYNC_POL = 1'b0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } lcd_state_e;

endpackage : lcd_timing_pkg
`default_nettype wire

// File: rtl/lcd_lock_sync.sv
`default_nettype none
// ============================================================================
// Module   : lcd_lock_sync
// Purpose  : Two-flop synchroniser bringing the PLL lock flag into the pixel
//            clock domain. Resets to 0 so the raster stays idle until lock is
//            seen for two consecutive edges.
// Ports    : clk_i   in  1  pixel clock
//            rst_ni  in  1  asynchronous active-low reset
//            async_i in  1  lock flag, asynchronous to clk_i
//            sync_o  out 1  synchronised lock flag
// Revision : 1.0 - initial release
// ============================================================================
module lcd_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule : lcd_lock_sync
`default_nettype wire

// File: rtl/lcd_sync_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_sync_timing_gen
// Purpose  : 800x480 LCD raster timing (HS, VS, DE) plus pixel read requests.
//            Returned RGB is registered onto the panel bus, aligned with DE.
//            Idle until the PLL reports lock; any loss of lock drops back to
//            idle and the next lock restarts the frame at pixel (0,0).
// Ports    : iCLK         in  1   33 MHz pixel clock
//            iRST_n       in  1   asynchronous active-low reset
//            iPLL_LOCKED  in  1   PLL lock, asynchronous to iCLK
//            oREQ         out 1   pixel request, iRGB answers 1 cycle later
//            oX / oY      out 10/9 requested column / row (0 when oREQ=0)
//            iRGB         in  24  {R,G,B} for the previous cycle's request
//            oHS / oVS    out 1   horizontal / vertical sync
//            oDE          out 1   data enable, aligned with oR/oG/oB
//            oR/oG/oB     out 8   pixel colour, 0 whenever oDE=0
//            oFRAME_START out 1   pulse with the request for pixel (0,0)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_sync_timing_gen #(
  parameter int H_ACTIVE = lcd_timing_pkg::H_ACTIVE,
  parameter int H_FP     = lcd_timing_pkg::H_FP,
  parameter int H_SYNC   = lcd_timing_pkg::H_SYNC,
  parameter int H_BP     = lcd_timing_pkg::H_BP,
  parameter int V_ACTIVE = lcd_timing_pkg::V_ACTIVE,
  parameter int V_FP     = lcd_timing_pkg::V_FP,
  parameter int V_SYNC   = lcd_timing_pkg::V_SYNC,
  parameter int V_BP     = lcd_timing_pkg::V_BP,
  parameter bit SYNC_POL = lcd_timing_pkg::SYNC_POL
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iPLL_LOCKED,
  output logic        oREQ,
  output logic [9:0]  oX,
  output logic [8:0]  oY,
  input  logic [23:0] iRGB,
  output logic        oHS,
  output logic        oVS,
  output logic        oDE,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oFRAME_START
);

  import lcd_timing_pkg::*;

  // Counter boundaries, pre-sized to the counter widths so every test is a
  // plain equal-width compare.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_ACT_END = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        lock_s;

  lcd_lock_sync u_lock_sync (
    .clk_i  (iCLK),
    .rst_ni (iRST_n),
    .async_i(iPLL_LOCKED),
    .sync_o (lock_s)
  );

  lcd_state_e  state_q;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  // Stage 0 decode of the current counter position.
  logic        active_d;
  logic        hs_a_d;
  logic        vs_a_d;
  logic        fs_d;

  // Stage 0 registers (request side).
  logic        req_q;
  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic        fs_q;
  logic        hs0_q, vs0_q;

  // Stage 1 registers: iRGB for the stage-0 request arrives during this stage.
  logic        de1_q, hs1_q, vs1_q;

  // Stage 2 registers (panel side).
  logic        de_q, hs_q, vs_q;
  logic [7:0]  r_q, g_q, b_q;

  always_comb begin
    active_d = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    hs_a_d   = (h_q >= HS_BEG) && (h_q < HS_END);
    vs_a_d   = (v_q >= VS_BEG) && (v_q < VS_END);
    fs_d     = active_d && (h_q == 11'd0) && (v_q == 10'd0);

    h_d = h_q + 11'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = 11'd0;
      v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  // The IDLE->RUN edge already registers the request for pixel (0,0), so the
  // first oREQ appears three clocks after lock rises (two synchroniser flops
  // plus this edge). In IDLE with no lock everything already sits at its idle
  // value and simply holds.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      h_q     <= 11'd0;
      v_q     <= 10'd0;
      req_q   <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
      fs_q    <= 1'b0;
      hs0_q   <= 1'b0;
      vs0_q   <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
    end else if ((state_q == RUN) && !lock_s) begin
      // Lock lost: abandon the frame, flush the pipeline, restart at (0,0).
      state_q <= IDLE;
      h_q     <= 11'd0;
      v_q     <= 10'd0;
      req_q   <= 1'b0;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
      fs_q    <= 1'b0;
      hs0_q   <= 1'b0;
      vs0_q   <= 1'b0;
      de1_q   <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      r_q     <= 8'd0;
      g_q     <= 8'd0;
      b_q     <= 8'd0;
    end else if (lock_s) begin
      state_q <= RUN;
      h_q     <= h_d;
      v_q     <= v_d;
      // Stage 0
      req_q   <= active_d;
      x_q     <= active_d ? h_q[9:0] : 10'd0;
      y_q     <= active_d ? v_q[8:0] : 9'd0;
      fs_q    <= fs_d;
      hs0_q   <= hs_a_d;
      vs0_q   <= vs_a_d;
      // Stage 1
      de1_q   <= req_q;
      hs1_q   <= hs0_q;
      vs1_q   <= vs0_q;
      // Stage 2: iRGB answers the request that de1_q is tracking.
      de_q    <= de1_q;
      hs_q    <= hs1_q ^ ~SYNC_POL;
      vs_q    <= vs1_q ^ ~SYNC_POL;
      r_q     <= de1_q ? iRGB[23:16] : 8'd0;
      g_q     <= de1_q ? iRGB[15:8]  : 8'd0;
      b_q     <= de1_q ? iRGB[7:0]   : 8'd0;
    end
  end

  assign oREQ         = req_q;
  assign oX           = x_q;
  assign oY           = y_q;
  assign oFRAME_START = fs_q;
  assign oDE          = de_q;
  assign oHS          = hs_q;
  assign oVS          = vs_q;
  assign oR           = r_q;
  assign oG           = g_q;
  assign oB           = b_q;

endmodule : lcd_sync_timing_gen
`default_nettype wire
